// File: rtl/sweep_fifo_loader_pkg.sv
// Shared sweep-record layout: word order, FIFO field offsets and loader FSM encoding.
// The sweep generator's FIFO unpacking uses the same offsets, so change them only here.
package sweep_fifo_loader_pkg;

  localparam int REC_WORDS = 6;
  localparam int WORD_W    = 32;
  localparam int REC_BITS  = 196;

  localparam int AMP_LSB   = 0;
  localparam int AMP_W     = 16;
  localparam int NCLK_LSB  = 16;
  localparam int STEP_LSB  = 48;
  localparam int FFIN_LSB  = 112;
  localparam int FINI_LSB  = 144;
  localparam int PAD_LSB   = 176;

  localparam logic [2:0] W0 = 3'd0;
  localparam logic [2:0] W1 = 3'd1;
  localparam logic [2:0] W2 = 3'd2;
  localparam logic [2:0] W3 = 3'd3;
  localparam logic [2:0] W4 = 3'd4;
  localparam logic [2:0] W5 = 3'd5;

  typedef enum logic [1:0] {
    L_IDLE    = 2'd0,
    L_COLLECT = 2'd1,
    L_CHECK   = 2'd2,
    L_WRITE   = 2'd3
  } load_state_t;

  // Bits from PAD_LSB upward stay zero.
  function automatic logic [REC_BITS-1:0] pack_record(
    input logic [WORD_W-1:0] f_init,
    input logic [WORD_W-1:0] f_final,
    input logic [WORD_W-1:0] step_hi,
    input logic [WORD_W-1:0] step_lo,
    input logic [WORD_W-1:0] n_clk,
    input logic [WORD_W-1:0] amp_word
  );
    logic [REC_BITS-1:0] r;
    r = '0;
    r[AMP_LSB  +: AMP_W]      = amp_word[AMP_W-1:0];
    r[NCLK_LSB +: WORD_W]     = n_clk;
    r[STEP_LSB +: 2*WORD_W]   = {step_hi, step_lo};
    r[FFIN_LSB +: WORD_W]     = f_final;
    r[FINI_LSB +: WORD_W]     = f_init;
    return r;
  endfunction

endpackage

// File: rtl/sweep_record_checker.sv
// Combinational record validation: nonzero clock count, amplitude fits in 16 bits.
// Zero latency, no flow control.
module sweep_record_checker (
  input  logic [31:0] number_of_clock,
  input  logic [31:0] amp_word,
  output logic        rec_ok
);

  assign rec_ok = (number_of_clock != 32'd0) && (amp_word[31:16] == 16'd0);

endmodule

// File: rtl/sweep_fifo_loader.sv
// Collects six host words into one sweep record and writes it to the FIFO in a single strobe.
// Write strobe 3 cycles after the last word; holds in L_WRITE (word_ready low) while the FIFO is full.
module sweep_fifo_loader #(
  parameter int REC_WORDS = 6,
  parameter int FIFO_W    = 196
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              word_valid,
  input  logic              word_sop,
  input  logic [31:0]       word_data,
  output logic              word_ready,
  input  logic              clear_cmd,
  output logic              fifo_wr_req,
  output logic [FIFO_W-1:0] fifo_wr_data,
  input  logic              fifo_wr_full,
  output logic [15:0]       records_written,
  output logic              error_flag,
  output logic [7:0]        error_count
);

  import sweep_fifo_loader_pkg::*;

  load_state_t state, next_state;
  logic [2:0]  idx, next_idx;
  logic [31:0] words [REC_WORDS];

  logic        accept;
  logic        store_w;
  logic [2:0]  store_idx;
  logic        err_evt;
  logic        do_write;
  logic        load_data;
  logic        rec_ok;

  sweep_record_checker u_checker (
    .number_of_clock (words[W4]),
    .amp_word        (words[W5]),
    .rec_ok          (rec_ok)
  );

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state <= L_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    next_idx   = idx;
    store_w    = 1'b0;
    store_idx  = idx;
    err_evt    = 1'b0;
    do_write   = 1'b0;
    load_data  = 1'b0;
    // Gated by reset so the host sees not-ready while reset is held.
    word_ready = !reset && ((state == L_IDLE) || (state == L_COLLECT));
    accept     = word_valid && word_ready;

    if (clear_cmd) begin
      next_state = L_IDLE;
      next_idx   = W0;
    end else begin
      case (state)
        L_IDLE: begin
          if (accept) begin
            if (word_sop) begin
              store_w    = 1'b1;
              store_idx  = W0;
              next_idx   = W1;
              next_state = L_COLLECT;
            end else begin
              err_evt = 1'b1;
            end
          end
        end
        L_COLLECT: begin
          if (accept) begin
            store_w = 1'b1;
            if (word_sop) begin
              err_evt   = 1'b1;
              store_idx = W0;
              next_idx  = W1;
            end else if (idx == 3'(REC_WORDS - 1)) begin
              next_idx   = W0;
              next_state = L_CHECK;
            end else begin
              next_idx = idx + 3'd1;
            end
          end
        end
        L_CHECK: begin
          if (rec_ok) begin
            load_data  = 1'b1;
            next_state = L_WRITE;
          end else begin
            err_evt    = 1'b1;
            next_state = L_IDLE;
          end
        end
        L_WRITE: begin
          if (!fifo_wr_full) begin
            do_write   = 1'b1;
            next_state = L_IDLE;
          end
        end
        default: next_state = L_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      idx             <= W0;
      fifo_wr_req     <= 1'b0;
      fifo_wr_data    <= '0;
      records_written <= 16'd0;
      error_flag      <= 1'b0;
      error_count     <= 8'd0;
      for (int i = 0; i < REC_WORDS; i++) begin
        words[i] <= 32'd0;
      end
    end else begin
      idx         <= next_idx;
      fifo_wr_req <= do_write;
      if (do_write) begin
        records_written <= records_written + 16'd1;
      end
      // Captured once on entry to L_WRITE so the data stays stable while full holds us off.
      if (load_data) begin
        fifo_wr_data <= FIFO_W'(pack_record(words[W0], words[W1], words[W2],
                                            words[W3], words[W4], words[W5]));
      end
      if (store_w) begin
        words[store_idx] <= word_data;
      end
      if (clear_cmd) begin
        error_flag  <= 1'b0;
        error_count <= 8'd0;
      end else if (err_evt) begin
        error_flag <= 1'b1;
        if (error_count != 8'hFF) begin
          error_count <= error_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sweep_fifo_loader.sv
// Directed bench for sweep_fifo_loader; expected FIFO records are queued at stimulus
// time and popped by an independent monitor on every write strobe.
module tb_sweep_fifo_loader;

  logic         clk_50 = 1'b0;
  logic         reset = 1'b1;
  logic         word_valid = 1'b0;
  logic         word_sop = 1'b0;
  logic [31:0]  word_data = 32'd0;
  logic         word_ready;
  logic         clear_cmd = 1'b0;
  logic         fifo_wr_req;
  logic [195:0] fifo_wr_data;
  logic         fifo_wr_full = 1'b0;
  logic [15:0]  records_written;
  logic         error_flag;
  logic [7:0]   error_count;

  int checks = 0;
  int failures = 0;
  logic [195:0] exp_q [$];
  logic [195:0] rec_a;

  sweep_fifo_loader #(.REC_WORDS(6), .FIFO_W(196)) dut (
    .clk_50          (clk_50),
    .reset           (reset),
    .word_valid      (word_valid),
    .word_sop        (word_sop),
    .word_data       (word_data),
    .word_ready      (word_ready),
    .clear_cmd       (clear_cmd),
    .fifo_wr_req     (fifo_wr_req),
    .fifo_wr_data    (fifo_wr_data),
    .fifo_wr_full    (fifo_wr_full),
    .records_written (records_written),
    .error_flag      (error_flag),
    .error_count     (error_count)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [195:0] act, input logic [195:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [195:0] exp_pack(input logic [31:0] w0, w1, w2, w3, w4, w5);
    return {20'h0, w0, w1, w2, w3, w4, w5[15:0]};
  endfunction

  always @(negedge clk_50) begin
    if (!reset && fifo_wr_req) begin
      check("wr_req_while_full", 32'(fifo_wr_full), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%0h expected=no_write", fifo_wr_data);
      end else begin
        check_data("wr_data", fifo_wr_data, exp_q.pop_front());
      end
    end
  end

  task automatic send_word(input logic sop, input logic [31:0] d);
    int n = 0;
    while (!word_ready && n < 50) begin
      @(posedge clk_50); #1;
      n++;
    end
    if (!word_ready) check("word_ready_timeout", 32'(word_ready), 32'd1);
    word_valid = 1'b1;
    word_sop   = sop;
    word_data  = d;
    @(posedge clk_50); #1;
    word_valid = 1'b0;
    word_sop   = 1'b0;
  endtask

  task automatic send_rec(input logic [31:0] w0, w1, w2, w3, w4, w5);
    send_word(1'b1, w0);
    send_word(1'b0, w1);
    send_word(1'b0, w2);
    send_word(1'b0, w3);
    send_word(1'b0, w4);
    send_word(1'b0, w5);
  endtask

  initial begin
    // Reset values while reset is held
    repeat (3) @(negedge clk_50);
    check("rst_word_ready", 32'(word_ready), 32'd0);
    check("rst_wr_req", 32'(fifo_wr_req), 32'd0);
    check_data("rst_wr_data", fifo_wr_data, 196'd0);
    check("rst_records", 32'(records_written), 32'd0);
    check("rst_err_flag", 32'(error_flag), 32'd0);
    check("rst_err_count", 32'(error_count), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", 32'(word_ready), 32'd1);
    @(posedge clk_50); #1;

    // Basic record and write latency
    rec_a = exp_pack(32'h01000000, 32'h02000000, 32'h0, 32'h00001000, 32'd100, 32'h7FFF);
    exp_q.push_back(rec_a);
    send_rec(32'h01000000, 32'h02000000, 32'h0, 32'h00001000, 32'd100, 32'h7FFF);
    @(negedge clk_50); check("lat_n0", 32'(fifo_wr_req), 32'd0);
    @(negedge clk_50); check("lat_n1", 32'(fifo_wr_req), 32'd0);
    @(negedge clk_50); check("lat_n2", 32'(fifo_wr_req), 32'd1);
    @(negedge clk_50); check("lat_n3", 32'(fifo_wr_req), 32'd0);
    check("records_1", 32'(records_written), 32'd1);

    // Backpressure: full held for 10 cycles
    fifo_wr_full = 1'b1;
    exp_q.push_back(rec_a);
    send_rec(32'h01000000, 32'h02000000, 32'h0, 32'h00001000, 32'd100, 32'h7FFF);
    repeat (2) @(negedge clk_50);
    for (int i = 0; i < 10; i++) begin
      check("hold_req", 32'(fifo_wr_req), 32'd0);
      check("hold_ready", 32'(word_ready), 32'd0);
      check_data("hold_data", fifo_wr_data, rec_a);
      @(negedge clk_50);
    end
    @(posedge clk_50); #1;
    fifo_wr_full = 1'b0;
    @(negedge clk_50); check("bp_req_pre", 32'(fifo_wr_req), 32'd0);
    @(negedge clk_50); check("bp_req_on", 32'(fifo_wr_req), 32'd1);
    @(negedge clk_50); check("bp_req_off", 32'(fifo_wr_req), 32'd0);
    check("records_2", 32'(records_written), 32'd2);

    // Zero clock count is dropped
    @(posedge clk_50); #1;
    send_rec(32'h1, 32'h2, 32'h3, 32'h4, 32'd0, 32'h55);
    repeat (4) @(negedge clk_50);
    check("nclk0_flag", 32'(error_flag), 32'd1);
    check("nclk0_count", 32'(error_count), 32'd1);
    check("nclk0_records", 32'(records_written), 32'd2);

    exp_q.push_back(exp_pack(32'h0A0B0C0D, 32'h11223344, 32'hDEADBEEF, 32'h01234567, 32'd5000, 32'h1234));
    send_rec(32'h0A0B0C0D, 32'h11223344, 32'hDEADBEEF, 32'h01234567, 32'd5000, 32'h1234);
    repeat (4) @(negedge clk_50);
    check("records_3", 32'(records_written), 32'd3);

    // Amplitude upper bits set is dropped
    send_rec(32'h1, 32'h2, 32'h3, 32'h4, 32'd7, 32'h00010001);
    repeat (4) @(negedge clk_50);
    check("amp_hi_count", 32'(error_count), 32'd2);
    check("amp_hi_records", 32'(records_written), 32'd3);

    // sop arriving at index 3 restarts the record
    send_word(1'b1, 32'hAAAA0000);
    send_word(1'b0, 32'hAAAA0001);
    send_word(1'b0, 32'hAAAA0002);
    exp_q.push_back(exp_pack(32'h00C0FFEE, 32'h00BEEF00, 32'h1, 32'h2, 32'd3, 32'hFFFF));
    send_rec(32'h00C0FFEE, 32'h00BEEF00, 32'h1, 32'h2, 32'd3, 32'hFFFF);
    repeat (4) @(negedge clk_50);
    check("resop_count", 32'(error_count), 32'd3);
    check("records_4", 32'(records_written), 32'd4);

    // clear_cmd in L_WRITE with full high discards the record
    fifo_wr_full = 1'b1;
    send_rec(32'h5, 32'h6, 32'h7, 32'h8, 32'd9, 32'h10);
    repeat (2) @(negedge clk_50);
    @(posedge clk_50); #1;
    clear_cmd = 1'b1;
    @(posedge clk_50); #1;
    clear_cmd = 1'b0;
    fifo_wr_full = 1'b0;
    repeat (10) @(negedge clk_50);
    check("clr_count", 32'(error_count), 32'd0);
    check("clr_flag", 32'(error_flag), 32'd0);
    check("clr_records", 32'(records_written), 32'd4);
    check("clr_ready", 32'(word_ready), 32'd1);

    // Error counter saturates
    @(posedge clk_50); #1;
    for (int i = 0; i < 260; i++) send_word(1'b0, 32'(i));
    @(negedge clk_50);
    check("sat_count", 32'(error_count), 32'd255);
    check("sat_flag", 32'(error_flag), 32'd1);
    check("sat_records", 32'(records_written), 32'd4);

    // Error coinciding with clear is lost
    @(posedge clk_50); #1;
    word_valid = 1'b1;
    word_sop   = 1'b0;
    clear_cmd  = 1'b1;
    @(posedge clk_50); #1;
    word_valid = 1'b0;
    clear_cmd  = 1'b0;
    @(negedge clk_50);
    check("clr_err_count", 32'(error_count), 32'd0);
    check("clr_err_flag", 32'(error_flag), 32'd0);

    // Reset mid-record
    @(posedge clk_50); #1;
    send_word(1'b1, 32'h11);
    send_word(1'b0, 32'h22);
    send_word(1'b0, 32'h33);
    reset = 1'b1;
    @(negedge clk_50);
    check("mid_rst_ready", 32'(word_ready), 32'd0);
    check("mid_rst_req", 32'(fifo_wr_req), 32'd0);
    check_data("mid_rst_data", fifo_wr_data, 196'd0);
    check("mid_rst_records", 32'(records_written), 32'd0);
    check("mid_rst_err", 32'(error_count), 32'd0);
    @(posedge clk_50); #1;
    reset = 1'b0;
    repeat (10) @(negedge clk_50);
    check("post_rst_records", 32'(records_written), 32'd0);
    check("post_rst_ready", 32'(word_ready), 32'd1);
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
